// File: rtl/dds_sweep_controller.sv
// rtl/dds_sweep_controller.sv - stepped linear frequency sweep sequencer for the DDS tuning word
// Config is shadowed on start; each point is held dwell+1 clocks, then stepped, restarted or finished.
module dds_sweep_controller #(
  parameter int FTW_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FTW_W-1:0] cfg_start_ftw,
  input  logic [FTW_W-1:0] cfg_step_ftw,
  input  logic [CNT_W-1:0] cfg_num_steps,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic             cfg_down,
  input  logic             cfg_repeat,
  output logic [FTW_W-1:0] freq_tuning_word,
  output logic             step_strobe,
  output logic [CNT_W-1:0] step_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t           state, state_d;
  logic [FTW_W-1:0] sh_start_ftw, sh_step_ftw, ftw_d;
  logic [CNT_W-1:0] sh_num_steps, sh_dwell, dwell_cnt, cnt_d, index_d;
  logic             sh_down, sh_repeat;
  logic             strobe_d, busy_d, done_d, accept;

  always_comb begin
    state_d  = state;
    ftw_d    = freq_tuning_word;
    index_d  = step_index;
    cnt_d    = dwell_cnt;
    strobe_d = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    accept   = 1'b0;
    if (abort) begin
      // abort outranks start and suppresses done
      state_d = IDLE;
      ftw_d   = '0;
      index_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accept   = 1'b1;
            state_d  = DWELL;
            ftw_d    = cfg_start_ftw;
            index_d  = '0;
            cnt_d    = '0;
            strobe_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        DWELL: begin
          if (dwell_cnt == sh_dwell) begin
            cnt_d = '0;
            if (step_index < sh_num_steps) begin
              ftw_d    = sh_down ? freq_tuning_word - sh_step_ftw
                                 : freq_tuning_word + sh_step_ftw;
              index_d  = step_index + CNT_W'(1);
              strobe_d = 1'b1;
            end else if (sh_repeat) begin
              ftw_d    = sh_start_ftw;
              index_d  = '0;
              strobe_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = dwell_cnt + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      freq_tuning_word <= '0;
      step_index       <= '0;
      dwell_cnt        <= '0;
      step_strobe      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sh_start_ftw     <= '0;
      sh_step_ftw      <= '0;
      sh_num_steps     <= '0;
      sh_dwell         <= '0;
      sh_down          <= 1'b0;
      sh_repeat        <= 1'b0;
    end else begin
      state            <= state_d;
      freq_tuning_word <= ftw_d;
      step_index       <= index_d;
      dwell_cnt        <= cnt_d;
      step_strobe      <= strobe_d;
      busy             <= busy_d;
      done             <= done_d;
      if (accept) begin
        sh_start_ftw <= cfg_start_ftw;
        sh_step_ftw  <= cfg_step_ftw;
        sh_num_steps <= cfg_num_steps;
        sh_dwell     <= cfg_dwell;
        sh_down      <= cfg_down;
        sh_repeat    <= cfg_repeat;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb/tb_dds_sweep_controller.sv - randomized bench for dds_sweep_controller against a closed-form sweep model
module tb_dds_sweep_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_start_ftw = '0;
  logic [31:0] cfg_step_ftw = '0;
  logic [15:0] cfg_num_steps = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_down = 1'b0;
  logic        cfg_repeat = 1'b0;
  logic [31:0] freq_tuning_word;
  logic        step_strobe;
  logic [15:0] step_index;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass = 0;

  dds_sweep_controller #(.FTW_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_start_ftw(cfg_start_ftw), .cfg_step_ftw(cfg_step_ftw),
    .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell),
    .cfg_down(cfg_down), .cfg_repeat(cfg_repeat),
    .freq_tuning_word(freq_tuning_word), .step_strobe(step_strobe),
    .step_index(step_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tuning word of point j: start +/- j*step, modulo 2^32.
  function automatic logic [31:0] ftw_of(input logic [31:0] s, input logic [31:0] st,
                                         input int j, input bit dn);
    logic [31:0] off;
    off = st * 32'(j);
    return dn ? s - off : s + off;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ftw"}, freq_tuning_word, 32'd0);
    check({tag, "_idx"}, 32'(step_index), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_strobe"}, 32'(step_strobe), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Starts a sweep and checks every cycle t after acceptance; abort_at < 0 means no abort.
  task automatic sweep(input logic [31:0] s, input logic [31:0] st, input int n, input int d,
                       input bit dn, input bit rp, input int cycles, input int abort_at,
                       input bit noise);
    int total, j, ph;
    logic [31:0] e_ftw;
    logic [15:0] e_idx;
    bit e_busy, e_strobe, e_done;
    cfg_start_ftw = s;
    cfg_step_ftw  = st;
    cfg_num_steps = 16'(n);
    cfg_dwell     = 16'(d);
    cfg_down      = dn;
    cfg_repeat    = rp;
    start         = 1'b1;
    total = (n + 1) * (d + 1);
    for (int t = 0; t < cycles; t++) begin
      step();
      if (abort_at >= 0 && t > abort_at) begin
        e_ftw = '0; e_idx = '0; e_busy = 0; e_strobe = 0; e_done = 0;
      end else if (rp || t < total) begin
        j = (t / (d + 1)) % (n + 1);
        ph = t % (d + 1);
        e_ftw = ftw_of(s, st, j, dn); e_idx = 16'(j);
        e_busy = 1; e_strobe = (ph == 0); e_done = 0;
      end else begin
        e_ftw = ftw_of(s, st, n, dn); e_idx = 16'(n);
        e_busy = 0; e_strobe = 0; e_done = (t == total);
      end
      check("ftw", freq_tuning_word, e_ftw);
      check("idx", 32'(step_index), 32'(e_idx));
      check("busy", 32'(busy), 32'(e_busy));
      check("strobe", 32'(step_strobe), 32'(e_strobe));
      check("done", 32'(done), 32'(e_done));
      abort = (t == abort_at);
      start = 1'b0;
      if (noise) begin
        cfg_start_ftw = $urandom;
        cfg_step_ftw  = $urandom;
        cfg_num_steps = 16'($urandom_range(0, 7));
        cfg_dwell     = 16'($urandom_range(0, 7));
        cfg_down      = 1'($urandom_range(0, 1));
        cfg_repeat    = 1'($urandom_range(0, 1));
        if ((rp || t < total - 1) && (abort_at < 0 || t <= abort_at))
          start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int n, d, ab, total;
    bit rp;
    #1;
    check_zero("reset");
    step();
    reset = 1'b0;
    step();
    check_zero("idle");

    sweep(32'd1000, 32'd100, 3, 2, 0, 0, 16, -1, 1);
    sweep(32'd50, 32'd100, 2, 0, 1, 0, 6, -1, 0);
    sweep(32'd123, 32'd9, 0, 0, 0, 0, 4, -1, 0);
    sweep(32'd10, 32'd5, 1, 1, 0, 1, 12, 7, 1);
    sweep(32'd1000, 32'd100, 3, 2, 0, 0, 12, 7, 0);

    // start and abort together in IDLE: nothing begins
    cfg_start_ftw = 32'd77; cfg_num_steps = 16'd2; cfg_dwell = 16'd1; cfg_repeat = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_zero("start_abort");
    step();
    check_zero("start_abort2");

    // asynchronous reset during point 1 of an up sweep
    sweep(32'd1000, 32'd100, 3, 2, 0, 0, 5, -1, 0);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    step();
    reset = 1'b0;
    sweep(32'd1000, 32'd100, 3, 2, 0, 0, 15, -1, 0);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 5);
      d = $urandom_range(0, 3);
      rp = 1'($urandom_range(0, 1));
      total = (n + 1) * (d + 1);
      if (rp) begin
        ab = $urandom_range(0, 3 * total + 2);
        sweep($urandom, $urandom, n, d, 1'($urandom_range(0, 1)), 1, ab + 3, ab, 1);
      end else if ($urandom_range(0, 2) == 0) begin
        ab = $urandom_range(0, total);
        sweep($urandom, $urandom, n, d, 1'($urandom_range(0, 1)), 0, ab + 3, ab, 1);
      end else begin
        sweep($urandom, $urandom, n, d, 1'($urandom_range(0, 1)), 0, total + 3, -1, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Sequencer that drives the `freq_tuning_word` input of the DDS sine generator to produce a stepped linear frequency sweep. Software-style configuration (start FTW, step, point count, dwell, direction, repeat) is latched on a start pulse. The block then walks the tuning word through the programmed points, holding each for a fixed number of clocks. It sits between the sweep/PLL control logic and the DDS and exposes a start/busy/done handshake plus a per-step strobe for downstream capture (e.g. phase detector sampling).

## Interface

- `FTW_W`, 32: tuning-word width; matches the DDS phase accumulator.
- `CNT_W`, 16: width of the point-count, dwell and index counters.

- `clk` in 1: system clock, same domain as the DDS.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a sweep; ignored while `busy`.
- `abort` in 1: terminates any sweep; wins over `start` in the same cycle.
- `cfg_start_ftw` in FTW_W: first tuning word.
- `cfg_step_ftw` in FTW_W: unsigned increment applied per point.
- `cfg_num_steps` in CNT_W: N; the sweep has N+1 points.
- `cfg_dwell` in CNT_W: D; each point is held for D+1 clocks.
- `cfg_down` in 1: 1 subtracts the step, 0 adds it.
- `cfg_repeat` in 1: 1 restarts from the start FTW after the last point, until `abort`.
- `freq_tuning_word` out FTW_W: registered tuning word to the DDS.
- `step_strobe` out 1: one-cycle pulse in the first cycle each new FTW is presented.
- `step_index` out CNT_W: index of the current point, 0..N.
- `busy` out 1: high while a sweep is active.
- `done` out 1: one-cycle pulse when a non-repeating sweep completes.

## Operation

- Reset values: `freq_tuning_word`=0, `step_strobe`=0, `step_index`=0, `busy`=0, `done`=0, state IDLE, all shadow registers 0.
- Config is latched into shadow registers when `start` is accepted. Changes to `cfg_*` while `busy` have no effect on the current sweep.
- **IDLE**
  - `start`=1 and `abort`=0: latch config, set `freq_tuning_word`=start FTW, `step_index`=0, dwell counter=0, pulse `step_strobe`, set `busy`=1, go to DWELL.
  - `freq_tuning_word` holds its last value, except that `abort` clears it to 0.
- **DWELL**
  - Dwell counter increments each cycle.
  - When the counter equals D, the hold for this point ends and exactly one of the following applies:
    - `step_index` < N: FTW = FTW ± step (modulo 2^FTW_W; wraps, never saturates), `step_index`+1, counter=0, pulse `step_strobe`.
    - `step_index` = N and repeat=1: FTW = start FTW, `step_index`=0, counter=0, pulse `step_strobe`.
    - `step_index` = N and repeat=0: go to IDLE, `busy`=0, pulse `done`. `freq_tuning_word` and `step_index` hold their final values.
- **Abort**
  - `abort` in any state: next cycle state=IDLE, `busy`=0, `freq_tuning_word`=0, `step_index`=0, `step_strobe`=0.
  - No `done` pulse is produced on abort.
- `start` while `busy` is ignored; the sweep is not restarted.
- `start` in the same cycle that `done` is produced is accepted next cycle only if still asserted (state is still DWELL on that edge).
- Asynchronous reset mid-sweep forces all reset values immediately. There is no resume after reset.

## Timing

- `start` sampled at edge k: first FTW, `step_strobe`, and `busy` are visible after edge k+1.
- Point j (0..N) is presented during cycles k+1+j(D+1) through k+j(D+1)+D+1.
- `step_strobe` is high only in the first cycle of each point.
- Non-repeat sweep: `busy` is high for exactly (N+1)(D+1) cycles. `done` is high in cycle k+1+(N+1)(D+1), the same cycle `busy` is low.
- `abort` sampled at edge m: outputs cleared after edge m+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Up sweep:** start=1000, step=100, N=3, D=2, down=0 -> FTW 1000, 1100, 1200, 1300, each for 3 cycles. Four `step_strobe` pulses. `busy` high 12 cycles. `done` pulse at cycle 13. FTW holds 1300 afterwards.
- **Down sweep with wrap:** start=50, step=100, N=2, D=0, down=1 -> FTW 50, 0xFFFFFFCE, 0xFFFFFF6A on consecutive cycles. `done` pulse after the third point.
- **Minimum sweep and repeat:**
  - N=0, D=0 -> one point for one cycle, `busy` high 1 cycle, `done` next cycle.
  - start=10, step=5, N=1, D=1, repeat=1 -> FTW pattern 10, 10, 15, 15, 10, 10… with no `done`.
  - `abort` then gives FTW=0 and `busy`=0 one cycle later.
- **Abort mid-sweep:** Up-sweep config, `abort` while `step_index`=2 -> next cycle FTW=0, `step_index`=0, `busy`=0. No `done` pulse.
- **Start while busy and config change:** During the up sweep, pulse `start` with start=7 and change `cfg_step_ftw`=1 -> sweep continues 1000…1300 unchanged. Also, `start`+`abort` in the same IDLE cycle -> no sweep begins and FTW=0.
- **Reset mid-sweep:** Assert `reset` asynchronously between edges during the DWELL of point 1 -> all outputs return to 0 without waiting for a clock edge. After release, a fresh `start` behaves exactly as in the up-sweep test.
